// File: rtl/bram_32_8_arb_pkg.sv
// Shared types and constants for the two-client arbiter on BRAM port A.
package bram_arb_pkg;

    localparam int unsigned BRAM_ADDR_W = 9;
    localparam int unsigned BRAM_DATA_W = 32;
    localparam int unsigned RD_LAT      = 3;

    typedef logic client_id_t;

    typedef struct packed {
        logic       vld;
        client_id_t id;
    } tag_t;

endpackage

// File: rtl/bram_32_8_arb_if.sv
// Client request/response and RAM port A signals grouped for the arbiter.
interface bram_32_8_arb_if
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = BRAM_ADDR_W,
    parameter int unsigned DATA_W = BRAM_DATA_W
);
    logic              req0_in,     req1_in;
    logic [3:0]        we0_in,      we1_in;
    logic [ADDR_W-1:0] addr0_in,    addr1_in;
    logic [DATA_W-1:0] wr_d0_in,    wr_d1_in;
    logic              gnt0_out,    gnt1_out;
    logic              rd_vld0_out, rd_vld1_out;
    logic [DATA_W-1:0] rd_d0_out,   rd_d1_out;
    logic              en_a_out;
    logic [3:0]        we_a_out;
    logic [ADDR_W-1:0] addr_a_out;
    logic [DATA_W-1:0] wr_d_a_out;
    logic [DATA_W-1:0] rd_d_a_in;

    modport master (
        output req0_in, req1_in, we0_in, we1_in, addr0_in, addr1_in,
               wr_d0_in, wr_d1_in, rd_d_a_in,
        input  gnt0_out, gnt1_out, rd_vld0_out, rd_vld1_out, rd_d0_out,
               rd_d1_out, en_a_out, we_a_out, addr_a_out, wr_d_a_out
    );

    modport slave (
        input  req0_in, req1_in, we0_in, we1_in, addr0_in, addr1_in,
               wr_d0_in, wr_d1_in, rd_d_a_in,
        output gnt0_out, gnt1_out, rd_vld0_out, rd_vld1_out, rd_d0_out,
               rd_d1_out, en_a_out, we_a_out, addr_a_out, wr_d_a_out
    );
endinterface

// File: rtl/bram_32_8_arb_rr_arb2.sv
// Two-way round-robin arbiter; BRAM_ARB_BURST_LIMIT_EN adds a burst counter
// letting the current owner keep the grant for up to MAX_BURST commands.
module rr_arb2
    import bram_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output client_id_t o_owner
);
    client_id_t r_last;
    client_id_t w_pick;
    logic       w_keep;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("rr_arb2: MAX_BURST out of range 1..255");
    end

`ifdef BRAM_ARB_BURST_LIMIT_EN
    localparam logic [7:0] MAX_B = MAX_BURST[7:0];
    logic [7:0] r_burst;

    // A zero count means the owner has no live burst, so the other side wins.
    assign w_keep = (r_burst != '0) && (r_burst < MAX_B);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_burst <= '0;
        end else if (|o_gnt) begin
            if (w_pick == r_last)
                r_burst <= (r_burst == '1) ? r_burst : r_burst + 8'd1;
            else
                r_burst <= 8'd1;
        end else if (!i_req[r_last]) begin
            r_burst <= '0;
        end
    end
`else
    assign w_keep = 1'b0;
`endif

    always_comb begin
        o_gnt  = '0;
        w_pick = r_last;
        case (i_req)
            2'b01:   w_pick = 1'b0;
            2'b10:   w_pick = 1'b1;
            2'b11:   w_pick = w_keep ? r_last : ~r_last;
            default: w_pick = r_last;
        endcase
        if (|i_req)
            o_gnt = w_pick ? 2'b10 : 2'b01;
    end

    assign o_owner = w_pick;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            r_last <= 1'b1;
        else if (|o_gnt)
            r_last <= w_pick;
    end
endmodule

// File: rtl/bram_32_8_arb.sv
// Arbitrates two 32-bit clients onto BRAM port A and routes read data back.
// Optional macro BRAM_ARB_BURST_LIMIT_EN enables burst-limited ownership.
module bram_32_8_arb
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = BRAM_ADDR_W,
    parameter int unsigned DATA_W    = BRAM_DATA_W,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    bram_32_8_arb_if.slave bus
);
    logic [1:0]        w_req;
    logic [1:0]        w_gnt_arb;
    logic [1:0]        w_gnt;
    logic              w_acc;
    client_id_t        w_sel;
    logic [3:0]        w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wd;

    logic              r_en;
    logic [3:0]        r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wd;
    tag_t              r_tag1, r_tag2;
    logic [1:0]        r_vld;
    logic [DATA_W-1:0] r_rd0, r_rd1;

    assign w_req = {bus.req1_in, bus.req0_in};

    rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .i_req    (w_req),
        .o_gnt    (w_gnt_arb),
        .o_owner  (w_sel)
    );

    // Grants are masked during reset so every output reads zero there.
    assign w_gnt  = w_gnt_arb & {2{rst_n_in}};
    assign w_acc  = |w_gnt;
    assign w_we   = w_sel ? bus.we1_in   : bus.we0_in;
    assign w_addr = w_sel ? bus.addr1_in : bus.addr0_in;
    assign w_wd   = w_sel ? bus.wr_d1_in : bus.wr_d0_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_en   <= 1'b0;
            r_we   <= '0;
            r_addr <= '0;
            r_wd   <= '0;
            r_tag1 <= '0;
            r_tag2 <= '0;
            r_vld  <= '0;
            r_rd0  <= '0;
            r_rd1  <= '0;
        end else begin
            r_en <= w_acc;
            if (w_acc) begin
                r_we   <= w_we;
                r_addr <= w_addr;
                r_wd   <= w_wd;
            end
            r_tag1 <= '{vld: w_acc && (w_we == 4'h0), id: w_sel};
            r_tag2 <= r_tag1;
            // r_tag2 lines up with the cycle rd_d_a_in is valid.
            r_vld  <= '0;
            if (r_tag2.vld) begin
                if (r_tag2.id) begin
                    r_rd1    <= bus.rd_d_a_in;
                    r_vld[1] <= 1'b1;
                end else begin
                    r_rd0    <= bus.rd_d_a_in;
                    r_vld[0] <= 1'b1;
                end
            end
        end
    end

    assign bus.gnt0_out    = w_gnt[0];
    assign bus.gnt1_out    = w_gnt[1];
    assign bus.rd_vld0_out = r_vld[0];
    assign bus.rd_vld1_out = r_vld[1];
    assign bus.rd_d0_out   = r_rd0;
    assign bus.rd_d1_out   = r_rd1;
    assign bus.en_a_out    = r_en;
    assign bus.we_a_out    = r_we;
    assign bus.addr_a_out  = r_addr;
    assign bus.wr_d_a_out  = r_wd;
endmodule

// File: tb/tb_bram_32_8_arb.sv
// Scoreboard bench for bram_32_8_arb with a behavioural port-A RAM model.
module tb_bram_32_8_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_vld0 = 0, n_vld1 = 0, n_en = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_32_8_arb_if #(.ADDR_W(9), .DATA_W(32)) bus ();

    bram_32_8_arb #(.ADDR_W(9), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    logic [31:0] mem     [512];
    logic [31:0] mem_ref [512];

    always @(posedge clk) begin
        if (bus.en_a_out) begin
            for (int b = 0; b < 4; b++)
                if (bus.we_a_out[b]) mem[bus.addr_a_out][b*8 +: 8] <= bus.wr_d_a_out[b*8 +: 8];
            bus.rd_d_a_in <= mem[bus.addr_a_out];
        end
    end

    typedef struct { logic [31:0] d; int c; } rexp_t;
    typedef struct { logic [3:0] we; logic [8:0] a; logic [31:0] d; int c; } cexp_t;
    rexp_t rq0[$], rq1[$];
    cexp_t cq[$];
    int    gseq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        rexp_t r;
        cexp_t c;
        logic [3:0] we; logic [8:0] a; logic [31:0] d;
        if (!rst_n) begin
            rq0.delete(); rq1.delete(); cq.delete();
        end else begin
            if (bus.rd_vld0_out) begin
                n_vld0++;
                if (rq0.size() == 0) check("rd0_unexpected", 32'(rq0.size()), 1);
                else begin
                    r = rq0.pop_front();
                    check("rd0_data", bus.rd_d0_out, r.d);
                    check("rd0_lat", 32'(cyc), 32'(r.c));
                end
            end
            if (bus.rd_vld1_out) begin
                n_vld1++;
                if (rq1.size() == 0) check("rd1_unexpected", 32'(rq1.size()), 1);
                else begin
                    r = rq1.pop_front();
                    check("rd1_data", bus.rd_d1_out, r.d);
                    check("rd1_lat", 32'(cyc), 32'(r.c));
                end
            end
            if (bus.en_a_out) begin
                n_en++;
                if (cq.size() == 0) check("en_unexpected", 32'(cq.size()), 1);
                else begin
                    c = cq.pop_front();
                    check("cmd_addr", 32'(bus.addr_a_out), 32'(c.a));
                    check("cmd_we", 32'(bus.we_a_out), 32'(c.we));
                    check("cmd_wd", bus.wr_d_a_out, c.d);
                    check("cmd_cyc", 32'(cyc), 32'(c.c));
                end
            end
            check("gnt_excl", 32'(bus.gnt0_out & bus.gnt1_out), 0);
            check("gnt_req", 32'((bus.gnt0_out & ~bus.req0_in) | (bus.gnt1_out & ~bus.req1_in)), 0);
            if ((bus.req0_in & bus.gnt0_out) | (bus.req1_in & bus.gnt1_out)) begin
                we = bus.gnt1_out ? bus.we1_in   : bus.we0_in;
                a  = bus.gnt1_out ? bus.addr1_in : bus.addr0_in;
                d  = bus.gnt1_out ? bus.wr_d1_in : bus.wr_d0_in;
                gseq.push_back(int'(bus.gnt1_out));
                cq.push_back('{we: we, a: a, d: d, c: cyc + 1});
                if (we == 4'h0) begin
                    r = '{d: mem_ref[a], c: cyc + 3};
                    if (bus.gnt1_out) rq1.push_back(r); else rq0.push_back(r);
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (we[b]) mem_ref[a][b*8 +: 8] = d[b*8 +: 8];
                end
            end
        end
    end

    task automatic issue(input bit cl, input logic [3:0] we, input logic [8:0] a, input logic [31:0] d);
        int n = 0;
        logic g;
        if (cl) begin bus.req1_in = 1'b1; bus.we1_in = we; bus.addr1_in = a; bus.wr_d1_in = d; end
        else    begin bus.req0_in = 1'b1; bus.we0_in = we; bus.addr0_in = a; bus.wr_d0_in = d; end
        do begin
            @(negedge clk);
            n++;
            g = cl ? bus.gnt1_out : bus.gnt0_out;
        end while (!g && n < 50);
        check(cl ? "grant_wait1" : "grant_wait0", 32'(g), 1);
        @(posedge clk); #1;
        if (cl) bus.req1_in = 1'b0; else bus.req0_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, v1, e0, c0;
        bus.req0_in = 0; bus.req1_in = 0;
        bus.we0_in = '0; bus.we1_in = '0;
        bus.addr0_in = '0; bus.addr1_in = '0;
        bus.wr_d0_in = '0; bus.wr_d1_in = '0;
        for (int i = 0; i < 512; i++) begin
            mem[i]     = 32'h5A000000 ^ (i * 32'h00010203);
            mem_ref[i] = mem[i];
        end
        mem[16] = 32'hDEADBEEF; mem_ref[16] = 32'hDEADBEEF;
        mem[5]  = 32'hAAAAAAAA; mem_ref[5]  = 32'hAAAAAAAA;

        @(posedge clk); #1;
        check("rst_en", 32'(bus.en_a_out), 0);
        check("rst_vld", 32'({bus.rd_vld0_out, bus.rd_vld1_out}), 0);
        check("rst_rd0", bus.rd_d0_out, 0);
        check("rst_addr", 32'(bus.addr_a_out), 0);
        do_reset();

        // Single read by client 0
        v1 = n_vld1;
        issue(0, 4'h0, 9'h010, '0);
        repeat (5) @(posedge clk); #1;
        check("t1_rd_d0", bus.rd_d0_out, 32'hDEADBEEF);
        check("t1_vld1_quiet", 32'(n_vld1 - v1), 0);

        // Continuous contention
        do_reset();
        gseq.delete();
        fork
            for (int i = 0; i < 8; i++) issue(0, 4'h0, 9'(32 + i), '0);
            for (int i = 0; i < 8; i++) issue(1, 4'h0, 9'(64 + i), '0);
        join
        repeat (5) @(posedge clk); #1;
        check("t2_ngrants", 32'(gseq.size()), 16);
        for (int i = 0; i < 16 && i < gseq.size(); i++) begin
`ifdef BRAM_ARB_BURST_LIMIT_EN
            check("t2_gnt_order", 32'(gseq[i]), 32'((i / 4) % 2));
`else
            check("t2_gnt_order", 32'(gseq[i]), 32'(i % 2));
`endif
        end

        // Partial write then read
        v1 = n_vld1;
        issue(1, 4'b0011, 9'd5, 32'h12345678);
        issue(0, 4'h0, 9'd5, '0);
        repeat (5) @(posedge clk); #1;
        check("t3_rd_merge", bus.rd_d0_out, 32'hAAAA5678);
        check("t3_wr_no_vld", 32'(n_vld1 - v1), 0);

        // Reset during an in-flight read
        do_reset();
        bus.req0_in = 1'b1; bus.we0_in = 4'h0; bus.addr0_in = 9'h010;
        @(negedge clk);
        check("t4_gnt0", 32'(bus.gnt0_out), 1);
        @(posedge clk); #1;
        bus.req0_in = 1'b0;
        check("t4_en_pre", 32'(bus.en_a_out), 1);
        rst_n = 1'b0;
        #1;
        check("t4_en", 32'(bus.en_a_out), 0);
        check("t4_we_addr", 32'({bus.we_a_out, bus.addr_a_out}), 0);
        check("t4_wd", bus.wr_d_a_out, 0);
        check("t4_vld", 32'({bus.rd_vld0_out, bus.rd_vld1_out}), 0);
        check("t4_rd0", bus.rd_d0_out, 0);
        check("t4_rd1", bus.rd_d1_out, 0);
        check("t4_gnt", 32'({bus.gnt0_out, bus.gnt1_out}), 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        v0 = n_vld0;
        repeat (6) @(posedge clk); #1;
        check("t4_no_vld_after", 32'(n_vld0 - v0), 0);
        gseq.delete();
        fork
            issue(0, 4'h0, 9'd1, '0);
            issue(1, 4'h0, 9'd2, '0);
        join
        check("t4_first_contention", 32'(gseq.size() > 0 ? gseq[0] : 9), 0);

        // Back-to-back single requester
        repeat (5) @(posedge clk); #1;
        v1 = n_vld1; e0 = n_en; c0 = cyc;
        for (int i = 0; i < 10; i++) issue(1, 4'h0, 9'(100 + i), '0);
        check("t5_span", 32'(cyc - c0), 10);
        repeat (5) @(posedge clk); #1;
        check("t5_en_count", 32'(n_en - e0), 10);
        check("t5_vld_count", 32'(n_vld1 - v1), 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bram_32_8_arb.md
# bram_32_8_arb

Two-requester arbiter sharing the 32-bit port A of the 16Kb 32/8 dual-port block RAM. Two 32-bit clients (e.g. the framebuffer fetch and the packet-assembly engine) issue word reads/byte-lane writes; the block grants one per cycle, drives the RAM port from a register stage, and returns read data to the issuing client with a valid strobe. Port B (8-bit) is untouched and stays with its own owner.

## Interface
- ADDR_W, 9, word address width (512 words)
- DATA_W, 32, data width
- MAX_BURST, 8, max consecutive grants to one client while the other waits (range 1..255)

- clk_in  in  1  single clock
- rst_n_in  in  1  asynchronous, active-low reset
- req0_in / req1_in  in  1  request; held with command fields stable until granted
- we0_in / we1_in  in  4  byte-lane write enables; 4'h0 = read
- addr0_in / addr1_in  in  ADDR_W  word address
- wr_d0_in / wr_d1_in  in  DATA_W  write data
- gnt0_out / gnt1_out  out  1  combinational grant; request accepted on edge where req&gnt
- rd_vld0_out / rd_vld1_out  out  1  one-cycle read-data strobe
- rd_d0_out / rd_d1_out  out  DATA_W  registered read data, held until next strobe to that client
- en_a_out  out  1  RAM port A enable
- we_a_out  out  4  RAM port A byte write enables
- addr_a_out  out  ADDR_W  RAM port A address
- wr_d_a_out  out  DATA_W  RAM port A write data
- rd_d_a_in  in  DATA_W  RAM port A read data (valid one cycle after en_a_out)

## Operation
- At most one grant per cycle; gnt0_out & gnt1_out never both high; gnt only asserted to a requesting client.
- Single requester: granted every cycle it requests (back-to-back, no bubbles).
- Both requesting: owner = last-granted client; other client has priority unless burst rule below lets owner continue.
- Accepted command registered into en_a_out/we_a_out/addr_a_out/wr_d_a_out; en_a_out low in cycles with no accept; we/addr/wr_d hold last value when idle.
- Read (we==4'h0): 2-bit tag pipeline {valid, client} follows the command; on return rd_d_a_in captured into that client's rd_d and its rd_vld pulses. Writes (we!=0) produce no rd_vld, including partial-lane writes.
- Ordering per client preserved; returns are in accept order.
- Reset: all outputs 0, tags cleared, last-granted = client 1 (client 0 wins first contention), burst count 0. Reset mid-transaction discards in-flight reads (no rd_vld after release).

## Timing
- Cycle T: req&gnt sampled at edge. T+1: en_a_out high with command. T+2: rd_d_a_in valid. T+3: rd_vld/rd_d out. Read latency 3 cycles from accept edge.
- Throughput 1 command/cycle total.
- Grant is combinational from req*_in and registered arbiter state only (no path from we/addr/data).
- Burst counter: increments on each accept by current owner; clears to 1 on owner change; clears to 0 when owner drops req. Saturates, no wrap.

## Configuration
- BRAM_ARB_BURST_LIMIT_EN defined: owner keeps grant under contention until burst count == MAX_BURST, then the other client gets the next grant.
- Not defined: pure round-robin per command (equivalent to MAX_BURST=1); burst counter not built; MAX_BURST ignored.

## Structure
- Package bram_arb_pkg: ADDR_W/DATA_W defaults, client-id type (1 bit), read-latency constant (3), tag struct {vld, id}.
- One sub-module: rr_arb2 (two-way round-robin with optional burst counter, outputs grant vector and owner).
- Top: command register, tag pipeline, per-client read-data registers.

## Test plan
- Reset released, req0 read addr 9'h010 (RAM preloaded 32'hDEADBEEF), req1 idle -> gnt0 same cycle, en_a_out at T+1 addr 9'h010, rd_vld0 at T+3 with rd_d0=32'hDEADBEEF; rd_vld1 stays 0.
- Both request reads continuously, macro off -> grants alternate 0,1,0,1 starting with client 0; rd_vld0/rd_vld1 alternate 3 cycles later with matching data.
- Macro on, MAX_BURST=4, both request continuously -> grant pattern 0,0,0,0,1,1,1,1,0...; each client's data returns in address order.
- Client 1 writes we=4'b0011 data 32'h12345678 to addr 5, then client 0 reads addr 5 (preloaded 32'hAAAAAAAA) -> write produces no rd_vld; read returns 32'hAAAA5678.
- Reset asserted at T+1 of an accepted read -> all outputs 0 immediately; no rd_vld after release; first contention then grants client 0.
- Single requester holds req1 for 10 cycles with incrementing addr -> 10 consecutive en_a_out cycles, no bubbles, 10 rd_vld1 pulses.
